// File: rtl/cut_mon_pkg.sv
// -----------------------------------------------------------------------------
// cut_mon_pkg
// Shared definitions for the cut switching-activity monitor:
//   - state_t      : monitor FSM states
//   - *_DEF        : default widths used by the top and the counters
//   - SIG_*        : bit positions of the monitored signals inside sig
// -----------------------------------------------------------------------------
package cut_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_SIG_DEF = 5;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

  // Positions inside sig: cut inputs n_1..n_4 in the low bits, cut output on top.
  localparam int SIG_N1  = 0;
  localparam int SIG_N2  = 1;
  localparam int SIG_N3  = 2;
  localparam int SIG_N4  = 3;
  localparam int SIG_OUT = 4;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset (count -> 0)
//   clear   in   synchronous clear, wins over inc
//   inc     in   add one this cycle (ignored once saturated)
//   q       out  current count
//   q_next  out  value q takes at the next edge
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] q_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    q_next = q;
    if (clear) begin
      q_next = '0;
    end else if (inc && (q != CNT_MAX)) begin
      q_next = q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/cut_activity_monitor.sv
// -----------------------------------------------------------------------------
// cut_activity_monitor
// Samples the four inputs and the output of a 4-input rewrite cut over a
// programmable window and accumulates, per signal, a toggle count and a ones
// count. Totals are read back through a registered select port.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a window (only honoured in IDLE)
//   win_len  in   number of counted cycles, captured with start
//   sig      in   {cut output, n_4, n_3, n_2, n_1}
//   busy     out  window in progress (PRIME or COUNT)
//   done     out  one-cycle pulse, results valid
//   rd_sel   in   counter select
//   rd_tog   out  toggle count of rd_sel (one cycle latency)
//   rd_ones  out  ones count of rd_sel (one cycle latency)
// -----------------------------------------------------------------------------
module cut_activity_monitor
  import cut_mon_pkg::*;
#(
  parameter int N_SIG = N_SIG_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  localparam int SEL_W = (N_SIG > 1) ? $clog2(N_SIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N_SIG-1:0] sig,
  output logic             busy,
  output logic             done,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_tog,
  output logic [CNT_W-1:0] rd_ones
);

  state_t           state;
  logic [WIN_W-1:0] remaining;
  logic [N_SIG-1:0] prev;

  logic             accept;
  logic             counting;
  logic [N_SIG-1:0] toggled;

  logic [CNT_W-1:0] tog_q     [N_SIG];
  logic [CNT_W-1:0] tog_next  [N_SIG];
  logic [CNT_W-1:0] ones_q    [N_SIG];
  logic [CNT_W-1:0] ones_next [N_SIG];

  logic [CNT_W-1:0] rd_tog_next;
  logic [CNT_W-1:0] rd_ones_next;

  // Any start seen in IDLE clears the counters, including a zero-length window.
  assign accept   = (state == IDLE) && start;
  assign counting = (state == COUNT);
  assign toggled  = sig ^ prev;

  // ---------------------------------------------------------------------------
  // Per-signal toggle and ones counters
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_SIG; gi++) begin : g_cnt
      sat_counter #(
        .CNT_W (CNT_W)
      ) u_tog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .inc    (counting && toggled[gi]),
        .q      (tog_q[gi]),
        .q_next (tog_next[gi])
      );

      sat_counter #(
        .CNT_W (CNT_W)
      ) u_ones (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .inc    (counting && sig[gi]),
        .q      (ones_q[gi]),
        .q_next (ones_next[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM, window counter and previous-sample register
  // busy/done are registered alongside the state so they follow it exactly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      prev      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (win_len != '0) begin
              remaining <= win_len;
              busy      <= 1'b1;
              state     <= PRIME;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        PRIME: begin
          // Reference sample only; the first counted toggle is against this.
          prev  <= sig;
          state <= COUNT;
        end
        COUNT: begin
          prev      <= sig;
          remaining <= remaining - 1'b1;
          if (remaining == WIN_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // In COUNT and IDLE the counters may change on this edge (last counted
  // sample, or the clear of a new window), so the post-edge value is read to
  // keep rd_* in step with the counters; that makes the final totals visible
  // in the done cycle. In PRIME and DONE the counters are frozen and the
  // stored value is read directly. Out-of-range selects read as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_tog_next  = '0;
    rd_ones_next = '0;
    for (int i = 0; i < N_SIG; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        if ((state == PRIME) || (state == DONE)) begin
          rd_tog_next  = tog_q[i];
          rd_ones_next = ones_q[i];
        end else begin
          rd_tog_next  = tog_next[i];
          rd_ones_next = ones_next[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tog  <= '0;
      rd_ones <= '0;
    end else begin
      rd_tog  <= rd_tog_next;
      rd_ones <= rd_ones_next;
    end
  end

endmodule

// File: doc/cut_activity_monitor.md
# cut_activity_monitor

Sequential switching-activity monitor placed directly downstream of a 4-input, 1-output rewrite sub-circuit in the power experiments. It samples the cut's four inputs and its output every cycle over a programmable window. It accumulates per-signal toggle counts and ones counts, from which transition density and signal probability are computed offline. It then exposes the totals through a registered read port, with a start/done handshake to the experiment harness.

## Interface
- N_SIG, 5, number of monitored signals (cut inputs n_1..n_4 plus cut output; index N_SIG-1 is the output)
- CNT_W, 16, width of each toggle/ones counter
- WIN_W, 16, width of window length
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a window; honoured only in IDLE
- win_len  in  WIN_W  number of counted cycles; captured on accepted start
- sig  in  N_SIG  {cut output, n_4, n_3, n_2, n_1}, MSB..LSB
- busy  out  1  high in PRIME and COUNT
- done  out  1  one-cycle pulse when results are valid
- rd_sel  in  $clog2(N_SIG)  counter select
- rd_tog  out  CNT_W  registered toggle count of signal rd_sel
- rd_ones  out  CNT_W  registered ones count of signal rd_sel

## Operation
- FSM states: IDLE, PRIME, COUNT, DONE.
- IDLE: if start=1 and win_len≠0, then latch win_len into remaining counter, clear all toggle/ones counters, go to PRIME. If start=1 and win_len=0, clear counters and go to DONE. The window is empty and all counts are 0.
- PRIME: capture sig into prev register; no counting; go to COUNT.
- COUNT, each cycle: for each i, tog[i] += (sig[i] ^ prev[i]); ones[i] += sig[i]; prev ← sig; remaining −= 1. When remaining reaches 1 and that cycle is counted, go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Counters saturate at 2^CNT_W−1; no wrap. Saturation is per counter and does not affect others.
- start while busy or in DONE: ignored, not queued.
- Counters hold their values in IDLE until the next accepted start, so results remain readable indefinitely.
- Reset (any state, including mid-window): FSM→IDLE; all counters, prev and remaining → 0; busy=0, done=0, rd_tog=0, rd_ones=0. No partial result is reported.

## Timing
- Accepted start at edge k: PRIME during cycle k+1; sig sampled at edges k+2 … k+1+win_len are counted; done high in cycle k+2+win_len.
- win_len=0: done high in cycle k+1.
- Maximum window 2^WIN_W−1 cycles.
- Back-to-back windows: earliest next accepted start is the cycle after done (IDLE).
- rd_tog/rd_ones: one-cycle latency from rd_sel. They are valid from the done cycle onward. Values read during busy are in-progress counts.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package cut_mon_pkg: state enum (IDLE, PRIME, COUNT, DONE), default widths, signal index constants (SIG_N1..SIG_N4, SIG_OUT).
- Sub-module sat_counter (CNT_W, clear, inc → q, saturating). It is instantiated 2×N_SIG.
- FSM, window counter, prev register and read mux live in the top.

## Test plan
- Reset mid-COUNT (win_len=10, deassert rst_n after 4 counted cycles) → busy=0, done never pulses, all reads return 0.
- sig=5'b00001 constant, win_len=8 → done at start+10 cycles; tog[0]=0, ones[0]=8, all other counts 0.
- sig toggles bit 4 every cycle starting from 0 (PRIME sees 0), win_len=6 → tog[4]=6, ones[4]=3, others 0.
- win_len=0 → done one cycle after start, busy never high, all counts 0.
- CNT_W=4, bit 2 toggling, win_len=40 → tog[2] saturates at 15, ones[2]=15; other counters unaffected.
- start pulsed again during COUNT and during DONE → ignored. A fresh start after done clears the counters and yields the second window's counts only.
